// File: rtl/spi_master.sv
// Single-byte SPI master with compile-time CPOL/CPHA.
// One tx_en pulse runs a fixed 17*CLK_DIV-cycle full-duplex transfer.
module spi_master #(
    parameter bit CPOL    = 1'b0,
    parameter bit CPHA    = 1'b0,
    parameter int CLK_DIV = 10
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] tx_data,
    input  logic       tx_en,
    input  logic       MISO,
    output logic       SCLK,
    output logic       MOSI,
    output logic       CS,
    output logic       spi_busy,
    output logic [7:0] rx_data,
    output logic       rx_done
);

    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT
    } state_t;

    state_t        state;
    logic [DW-1:0] div;
    logic [4:0]    ecnt;
    logic [7:0]    tx_sr;
    logic [7:0]    rx_sr;

    logic          tick;
    logic [4:0]    k;
    logic          lead;
    logic          samp;
    logic          shift_ev;

    // k is the number of the divider tick about to happen
    assign tick     = (div == DW'(CLK_DIV - 1));
    assign k        = ecnt + 5'd1;
    assign lead     = k[0];
    assign samp     = lead ^ CPHA;
    assign shift_ev = CPHA ? lead : (!lead && (k <= 5'd14));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            div      <= '0;
            ecnt     <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            SCLK     <= CPOL;
            MOSI     <= 1'b0;
            CS       <= 1'b1;
            spi_busy <= 1'b0;
            rx_data  <= '0;
            rx_done  <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_en) begin
                        tx_sr    <= tx_data;
                        rx_sr    <= '0;
                        CS       <= 1'b0;
                        spi_busy <= 1'b1;
                        div      <= '0;
                        ecnt     <= '0;
                        MOSI     <= CPHA ? 1'b0 : tx_data[7];
                        state    <= SETUP;
                    end
                end
                SETUP, SHIFT: begin
                    div <= tick ? '0 : div + 1'b1;
                    if (tick) begin
                        ecnt <= k;
                        if (k == 5'd17) begin
                            CS       <= 1'b1;
                            spi_busy <= 1'b0;
                            MOSI     <= 1'b0;
                            SCLK     <= CPOL;
                            rx_data  <= rx_sr;
                            rx_done  <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            SCLK  <= ~SCLK;
                            state <= SHIFT;
                            if (samp)
                                rx_sr <= {rx_sr[6:0], MISO};
                            // CPHA=0 preloads bit 7, so it shifts out bit 6 next
                            if (shift_ev) begin
                                MOSI  <= CPHA ? tx_sr[7] : tx_sr[6];
                                tx_sr <= {tx_sr[6:0], 1'b0};
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: four instances cover all CPOL/CPHA modes.
// Instance 0 has MISO tied high; instances 1..3 loop MOSI back to MISO.
module tb_spi_master;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] txd [4];
    logic       en [4];
    logic       sclk [4];
    logic       mosi [4];
    logic       cs [4];
    logic       busy [4];
    logic [7:0] rxd [4];
    logic       done [4];

    localparam bit [3:0] POL = 4'b1100;
    localparam bit [3:0] PHA = 4'b1001;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    spi_master #(.CPOL(1'b0), .CPHA(1'b1), .CLK_DIV(10)) u0 (
        .clk(clk), .rstn(rstn), .tx_data(txd[0]), .tx_en(en[0]),
        .MISO(1'b1), .SCLK(sclk[0]), .MOSI(mosi[0]), .CS(cs[0]),
        .spi_busy(busy[0]), .rx_data(rxd[0]), .rx_done(done[0])
    );
    spi_master #(.CPOL(1'b0), .CPHA(1'b0), .CLK_DIV(10)) u1 (
        .clk(clk), .rstn(rstn), .tx_data(txd[1]), .tx_en(en[1]),
        .MISO(mosi[1]), .SCLK(sclk[1]), .MOSI(mosi[1]), .CS(cs[1]),
        .spi_busy(busy[1]), .rx_data(rxd[1]), .rx_done(done[1])
    );
    spi_master #(.CPOL(1'b1), .CPHA(1'b0), .CLK_DIV(10)) u2 (
        .clk(clk), .rstn(rstn), .tx_data(txd[2]), .tx_en(en[2]),
        .MISO(mosi[2]), .SCLK(sclk[2]), .MOSI(mosi[2]), .CS(cs[2]),
        .spi_busy(busy[2]), .rx_data(rxd[2]), .rx_done(done[2])
    );
    spi_master #(.CPOL(1'b1), .CPHA(1'b1), .CLK_DIV(10)) u3 (
        .clk(clk), .rstn(rstn), .tx_data(txd[3]), .tx_en(en[3]),
        .MISO(mosi[3]), .SCLK(sclk[3]), .MOSI(mosi[3]), .CS(cs[3]),
        .spi_busy(busy[3]), .rx_data(rxd[3]), .rx_done(done[3])
    );

    // observations of the most recent transfer
    int         busy_n, cs_n, first_lead, leads, trails, last_edge;
    int         dones, done_at, mosi_bad, cs_falls;
    logic [7:0] samp_byte;
    logic       cs0, busy0, mosi0, mosi_end, sclk_end, snap_ok;

    // n counts falling clk edges after the accept edge A (n=0 is A + half)
    task automatic run_xfer(input int idx, input logic [7:0] d,
                            input int hold, input int win,
                            input bit poke, input int abort_at);
        logic ps, pm, pc;
        bit   cp, ch, lead, edge_seen;
        cp = POL[idx];
        ch = PHA[idx];
        busy_n = 0; cs_n = 0; first_lead = -1; leads = 0; trails = 0;
        last_edge = -1; dones = 0; done_at = -1; mosi_bad = 0;
        cs_falls = 0; samp_byte = 8'h00; snap_ok = 1'b1;
        mosi_end = 1'bx; sclk_end = 1'bx;
        ps = sclk[idx]; pm = mosi[idx]; pc = cs[idx];
        txd[idx] = d;
        en[idx] = 1'b1;
        for (int n = 0; n < win; n++) begin
            @(negedge clk);
            en[idx] = (n < hold - 1) ||
                      (poke && (n == 50 || n == 120 || n == 169));
            if (n == abort_at + 1)
                rstn = 1'b1;
            if (n == 0) begin
                cs0 = cs[idx]; busy0 = busy[idx]; mosi0 = mosi[idx];
            end else begin
                edge_seen = (sclk[idx] !== ps);
                lead = edge_seen && (sclk[idx] !== cp);
                if (edge_seen) begin
                    last_edge = n;
                    if (lead) begin
                        leads++;
                        if (first_lead < 0) first_lead = n;
                    end else begin
                        trails++;
                    end
                    if (lead ^ ch)
                        samp_byte = {samp_byte[6:0], pm};
                end
                // MOSI may only move on a shift edge or at transfer end
                if (mosi[idx] !== pm && n != 170 &&
                    !(edge_seen && !(lead ^ ch)))
                    mosi_bad++;
            end
            if (!cs[idx] && pc) cs_falls++;
            if (!cs[idx]) cs_n++;
            if (busy[idx]) busy_n++;
            if (done[idx]) begin dones++; done_at = n; end
            if (n == 170) begin mosi_end = mosi[idx]; sclk_end = sclk[idx]; end
            if (n == abort_at) begin
                rstn = 1'b0;
                #1;
                snap_ok = (sclk[idx] === cp) && (cs[idx] === 1'b1) &&
                          (mosi[idx] === 1'b0) && (busy[idx] === 1'b0) &&
                          (rxd[idx] === 8'h00) && (done[idx] === 1'b0);
            end
            ps = sclk[idx]; pm = mosi[idx]; pc = cs[idx];
        end
        en[idx] = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #100;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (sclk[i] !== POL[i]) begin
                errors++; $display("FAIL reset_sclk[%0d]: got %b want %b", i, sclk[i], POL[i]);
            end
            checks++;
            if (cs[i] !== 1'b1) begin
                errors++; $display("FAIL reset_cs[%0d]: got %b want 1", i, cs[i]);
            end
            checks++;
            if (mosi[i] !== 1'b0) begin
                errors++; $display("FAIL reset_mosi[%0d]: got %b want 0", i, mosi[i]);
            end
            checks++;
            if (busy[i] !== 1'b0 || done[i] !== 1'b0) begin
                errors++; $display("FAIL reset_busy_done[%0d]: got %b%b want 00", i, busy[i], done[i]);
            end
            checks++;
            if (rxd[i] !== 8'h00) begin
                errors++; $display("FAIL reset_rx[%0d]: got %h want 00", i, rxd[i]);
            end
        end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_cpha1();
        run_xfer(0, 8'h01, 1, 200, 1'b0, -10);
        checks++;
        if (cs0 !== 1'b0 || busy0 !== 1'b1 || mosi0 !== 1'b0) begin
            errors++; $display("FAIL cpha1_accept: got cs%b busy%b mosi%b want 010", cs0, busy0, mosi0);
        end
        checks++;
        if (first_lead !== 10) begin
            errors++; $display("FAIL cpha1_first_edge: got %0d want 10", first_lead);
        end
        checks++;
        if (leads !== 8 || trails !== 8 || last_edge !== 160) begin
            errors++; $display("FAIL cpha1_edges: got %0d/%0d last %0d want 8/8 last 160", leads, trails, last_edge);
        end
        checks++;
        if (samp_byte !== 8'h01) begin
            errors++; $display("FAIL cpha1_mosi_bits: got %h want 01", samp_byte);
        end
        checks++;
        if (mosi_bad !== 0) begin
            errors++; $display("FAIL cpha1_mosi_timing: got %0d bad changes want 0", mosi_bad);
        end
        checks++;
        if (busy_n !== 170) begin
            errors++; $display("FAIL cpha1_busy_len: got %0d want 170", busy_n);
        end
        checks++;
        if (dones !== 1 || done_at !== 170) begin
            errors++; $display("FAIL cpha1_done: got %0d at %0d want 1 at 170", dones, done_at);
        end
        checks++;
        if (rxd[0] !== 8'hFF) begin
            errors++; $display("FAIL cpha1_rx: got %h want ff", rxd[0]);
        end
        checks++;
        if (mosi_end !== 1'b0 || sclk_end !== 1'b0) begin
            errors++; $display("FAIL cpha1_end_idle: got mosi%b sclk%b want 00", mosi_end, sclk_end);
        end
    endtask

    task automatic test_second();
        repeat (10000) @(negedge clk);
        run_xfer(0, 8'h81, 1, 200, 1'b0, -10);
        checks++;
        if (samp_byte !== 8'h81) begin
            errors++; $display("FAIL second_mosi_bits: got %h want 81", samp_byte);
        end
        checks++;
        if (cs_n !== 170) begin
            errors++; $display("FAIL second_cs_len: got %0d want 170", cs_n);
        end
        checks++;
        if (rxd[0] !== 8'hFF || dones !== 1) begin
            errors++; $display("FAIL second_rx: got %h/%0d want ff/1", rxd[0], dones);
        end
    endtask

    task automatic test_modes();
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (sclk[i] !== POL[i]) begin
                errors++; $display("FAIL mode%0d_idle: got %b want %b", i, sclk[i], POL[i]);
            end
            run_xfer(i, 8'hA5, 1, 200, 1'b0, -10);
            checks++;
            if (rxd[i] !== 8'hA5 || dones !== 1) begin
                errors++; $display("FAIL mode%0d_rx: got %h/%0d want a5/1", i, rxd[i], dones);
            end
            checks++;
            if (samp_byte !== 8'hA5 || mosi_bad !== 0) begin
                errors++; $display("FAIL mode%0d_mosi: got %h bad %0d want a5 bad 0", i, samp_byte, mosi_bad);
            end
            checks++;
            if (mosi0 !== !PHA[i]) begin
                errors++; $display("FAIL mode%0d_first_bit: got %b want %b", i, mosi0, !PHA[i]);
            end
            checks++;
            if (sclk_end !== POL[i] || first_lead !== 10 || leads !== 8) begin
                errors++; $display("FAIL mode%0d_sclk: got end %b first %0d leads %0d", i, sclk_end, first_lead, leads);
            end
        end
    endtask

    task automatic test_ignore();
        run_xfer(1, 8'h3C, 5, 200, 1'b1, -10);
        checks++;
        if (cs_falls !== 1 || dones !== 1) begin
            errors++; $display("FAIL ignore_count: got falls %0d dones %0d want 1/1", cs_falls, dones);
        end
        checks++;
        if (busy_n !== 170 || rxd[1] !== 8'h3C) begin
            errors++; $display("FAIL ignore_xfer: got busy %0d rx %h want 170/3c", busy_n, rxd[1]);
        end
    endtask

    task automatic test_back_to_back();
        run_xfer(1, 8'h5A, 1, 171, 1'b0, -10);
        checks++;
        if (cs[1] !== 1'b1 || busy[1] !== 1'b0 || dones !== 1) begin
            errors++; $display("FAIL b2b_gap: got cs%b busy%b dones %0d want 1 0 1", cs[1], busy[1], dones);
        end
        run_xfer(1, 8'hC3, 1, 200, 1'b0, -10);
        checks++;
        if (cs0 !== 1'b0 || cs_falls !== 1) begin
            errors++; $display("FAIL b2b_accept: got cs%b falls %0d want 0/1", cs0, cs_falls);
        end
        checks++;
        if (rxd[1] !== 8'hC3 || dones !== 1) begin
            errors++; $display("FAIL b2b_rx: got %h/%0d want c3/1", rxd[1], dones);
        end
    endtask

    task automatic test_abort();
        run_xfer(2, 8'hF0, 1, 120, 1'b0, 70);
        checks++;
        if (snap_ok !== 1'b1) begin
            errors++; $display("FAIL abort_reset_values: got %b want 1", snap_ok);
        end
        checks++;
        if (leads !== 4 || trails !== 3) begin
            errors++; $display("FAIL abort_edges: got %0d/%0d want 4/3", leads, trails);
        end
        checks++;
        if (dones !== 0 || rxd[2] !== 8'h00 || busy[2] !== 1'b0) begin
            errors++; $display("FAIL abort_no_done: got %0d rx %h busy %b want 0 00 0", dones, rxd[2], busy[2]);
        end
        run_xfer(2, 8'h96, 1, 200, 1'b0, -10);
        checks++;
        if (rxd[2] !== 8'h96 || dones !== 1 || busy_n !== 170) begin
            errors++; $display("FAIL abort_recover: got %h/%0d/%0d want 96/1/170", rxd[2], dones, busy_n);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            en[i] = 1'b0;
            txd[i] = 8'h00;
        end
        test_reset();
        test_cpha1();
        test_second();
        test_modes();
        test_ignore();
        test_back_to_back();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_master.md
# spi_master

Single-byte SPI bus master with compile-time clock polarity and phase, in the host-side I/O region between internal control logic and an external SPI slave. A one-cycle `tx_en` pulse starts one 8-bit, MSB-first, full-duplex transfer, driving SCLK, MOSI and active-low CS. The byte received on MISO is presented at transfer end. Each transfer is a fixed length of 17 × CLK_DIV system clocks.

## Interface
- `CPOL`, default 0: SCLK idle level. The leading edge is the transition away from CPOL.
- `CPHA`, default 0: data phase.
  - 0: sample on the leading edge, shift on the trailing edge.
  - 1: shift on the leading edge, sample on the trailing edge.
- `CLK_DIV`, default 10: SCLK half-period in `clk` cycles; must be ≥ 2. SCLK = clk / (2·CLK_DIV).
- `clk` input 1: system clock, rising edge. Clock: one clock (`clk`); reset is asynchronous and active-low (`rstn`).
- `rstn` input 1: asynchronous active-low reset.
- `tx_data` input 8: byte to send; sampled only in the `tx_en` accept cycle.
- `tx_en` input 1: start request, one-cycle pulse.
- `MISO` input 1: serial data from the slave.
- `SCLK` output 1: serial clock.
- `MOSI` output 1: serial data to the slave.
- `CS` output 1: chip select, active low.
- `spi_busy` output 1: high while a transfer is in progress.
- `rx_data` output 8: last received byte.
- `rx_done` output 1: one-cycle pulse when `rx_data` updates.

## Operation
- All outputs are registered.
- Reset values: SCLK=CPOL, CS=1, MOSI=0, spi_busy=0, rx_data=0, rx_done=0; divider, bit counter and state cleared.
- FSM states:
  - IDLE: wait for a request.
  - SETUP: CS low, SCLK still idle, for one half-period.
  - SHIFT: 16 SCLK edges.
  - back to IDLE.
- IDLE → SETUP: on a clock edge with tx_en=1.
  - Latch tx_data into the shift register.
  - CS←0, spi_busy←1, divider←0.
- tx_en while spi_busy=1 is ignored; no queueing.
- tx_en held high for several cycles starts one transfer; a new transfer needs tx_en high again after spi_busy falls.
- Divider tick: every CLK_DIV cycles after acceptance. Tick k (k=1..16) toggles SCLK.
  - Odd k = leading edge.
  - Even k = trailing edge.
- MOSI, CPHA=0:
  - Bit 7 is driven in the cycle CS falls.
  - Bits 6..0 are driven at trailing edges 1..7.
  - The 8th trailing edge does not shift.
- MOSI, CPHA=1:
  - MOSI stays 0 during SETUP.
  - Bits 7..0 are driven at leading edges 1..8.
- MISO sampling:
  - Sampled on the clock edge that produces the sampling SCLK transition.
  - Shifted in MSB first.
- SHIFT → IDLE: at tick 17 (one half-period after the 16th SCLK edge).
  - CS←1, spi_busy←0, MOSI←0, SCLK=CPOL.
  - rx_data←assembled byte; rx_done=1 for that one cycle.
- A new tx_en is accepted in the cycle after spi_busy falls. CS is therefore high for at least one clk between transfers.
- Asynchronous reset asserted mid-transfer aborts immediately to the reset values. No rx_done is produced and rx_data is unchanged from reset (0).

## Timing
Let A = the clock edge sampling tx_en=1.
- After A: CS=0, spi_busy=1, and for CPHA=0 MOSI=tx_data[7].
- SCLK edge k occurs at A + k·CLK_DIV, for k=1..16.
- CS rises, spi_busy falls and rx_done pulses at A + 17·CLK_DIV.
- Default CLK_DIV=10 at 50 MHz: SCLK = 2.5 MHz, busy for 170 cycles = 3.4 µs.
- CS-to-first-edge setup and last-edge-to-CS hold are each one SCLK half-period.
- SCLK duty cycle is exactly 50%. No glitches on SCLK, CS or MOSI (all driven from flops).

## Test plan
- Reset check: rstn low 100 ns → SCLK=CPOL, CS=1, MOSI=0, spi_busy=0, rx_data=0x00.
- CPOL=0, CPHA=1, tx_en pulse with 0x01, MISO tied 1:
  - 8 rising/falling SCLK pairs; first rising edge 10 cycles after acceptance.
  - MOSI changes on rising edges and reads 0,0,0,0,0,0,0,1 on falling edges.
  - spi_busy high for 170 cycles; rx_data=0xFF with rx_done pulse.
- Second transfer 0x81 after 200 µs idle:
  - MOSI on sampling edges = 1,0,0,0,0,0,0,1.
  - CS low exactly 170 cycles.
- CPOL=0, CPHA=0 and CPOL=1, CPHA=0/1, 0xA5 looped MOSI→MISO:
  - SCLK idles at CPOL.
  - rx_data=0xA5 in all modes.
  - CPHA=0: MOSI=1 in the cycle CS falls.
- tx_en=1 pulses during spi_busy and tx_en held for 5 cycles → exactly one transfer. CS is high ≥1 cycle before a back-to-back transfer accepted the cycle after busy drops.
- rstn pulsed low at SCLK edge 7 → outputs return to reset values immediately, no rx_done. The next tx_en runs a complete normal transfer.
